decim_avg_tdm: RTL and testbench
================================

# decim_avg_tdm

Parametrised successor of the anti-aliasing decimation stage. It is a time-division multi-channel accumulate-and-dump decimator with a runtime-selectable power-of-two ratio, round-to-nearest averaging and a ready/valid handshake on both sides. It also generates the periodic clock-enable for the downstream FIR stage. It sits between the first anti-aliasing FIR and the second-stage FIR in the audio chain.

## Interface
- DATA_W, 24, sample width (signed two's complement)
- CH, 2, interleaved channel count (≥1)
- MAX_LOG2_RATIO, 4, largest log2 decimation ratio
- CLKEN_PERIOD, 55, fir_clk_en pulses once every CLKEN_PERIOD+1 cycles
- Reset and clock (already decided): reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush; zeroes all state
- log2_ratio  in  $clog2(MAX_LOG2_RATIO+1)  requested log2 ratio k; values above MAX are clamped to MAX
- in_data  in  DATA_W  input sample; channel order is implicit, 0..CH-1 repeating
- in_valid  in  1  input sample present
- in_ready  out  1  input accepted when in_valid && in_ready
- out_data  out  DATA_W  decimated average
- out_ch  out  $clog2(CH) (min 1)  channel of out_data
- out_valid  out  1  output present
- out_ready  in  1  output consumed when out_valid && out_ready
- fir_clk_en  out  1  one-cycle enable for the next filter stage

## Operation
- Per-channel accumulator acc[c] is DATA_W+MAX_LOG2_RATIO bits, sign-extended add.
- Channel counter ch_q steps 0..CH-1 and wraps on each accepted sample. Block counter blk_q counts 0..2^k−1 and advances when ch_q wraps.
- The active ratio is k_q. It is latched from log2_ratio only when ch_q==0 and blk_q==0 and a sample is accepted, or on reset/clear. A change in mid-block takes effect at the next block start.
- On an accepted sample while blk_q==2^k_q−1 (the dump sample for channel ch_q):
  - sum = acc[c] + in_data
  - out_data = (sum + (k_q>0 ? 2^(k_q−1) : 0)) >>> k_q, which is round-half-up
  - acc[c] ← 0; the output register is loaded with out_ch=c.
- Otherwise acc[c] ← acc[c] + in_data.
- With k_q=0, every sample passes straight through to the output register.
- The result always fits DATA_W, so no saturation logic is needed.
- in_ready = !out_valid || out_ready. The output is a single register; backpressure stalls input for all channels.
- clear has priority over all other activity:
  - zeroes acc, ch_q, blk_q, the clken counter and the start flag
  - drops out_valid
  - reloads k_q from clamped log2_ratio
- fir_clk_en generator:
  - start flag sets on the first output handshake and stays set until reset/clear.
  - While started, cnt runs 0..CLKEN_PERIOD and wraps.
  - fir_clk_en = start && cnt==CLKEN_PERIOD.

## Timing
- Reset values:
  - out_data=0, out_ch=0, out_valid=0
  - in_ready=1, since it follows out_valid=0
  - fir_clk_en=0
  - acc=0, ch_q=0, blk_q=0, k_q=0, cnt=0, start=0
- Latency: out_valid rises on the edge that accepts the dump sample, so it is visible the next cycle.
- Throughput: one sample per cycle when out_ready is held at 1.
- A simultaneous output handshake and dump sample loads the new output in the same edge; no bubble.
- out_data and out_ch are held stable while out_valid && !out_ready.
- The first fir_clk_en occurs CLKEN_PERIOD+1 cycles after the first output handshake edge, then repeats every CLKEN_PERIOD+1 cycles.
- Asynchronous reset mid-block discards partial sums and any pending output.

## Structure
- Package decim_pkg holds:
  - width functions acc_w(DATA_W,MAX_LOG2_RATIO) and chw(CH)
  - the ratio-clamp function
  - the rounding-offset function
- Sub-module decim_clken_gen(CLKEN_PERIOD) contains the start flag and period counter. Inputs: start_evt, clear. Output: fir_clk_en.
- The accumulators are a CH-deep register array, not RAM.

## Test plan
- CH=2, k=3, out_ready=1. Ch0 gets 1..8 and ch1 gets −3 ×8. Required response: out (ch0, 5) then (ch1, −3), each one cycle after its 8th sample.
- k=0: the stream 7, −7 gives outputs 7 (ch0) and −7 (ch1), each one cycle after acceptance, with in_ready constantly 1.
- Backpressure test:
  - Hold out_ready=0 after the first output. Required: in_ready=0 and out_data/out_ch are stable.
  - Release out_ready. Required: the next dump is accepted in the same cycle and there are no lost or duplicated samples.
- Change log2_ratio 3→1 at blk_q=4. Required: the current block still outputs the average of 8 samples, and the following blocks average pairs; for example, 2,3 → 3.
- Assert clear at blk_q=5 with out_valid=1. Required: out_valid=0 next cycle, and a fresh full block is needed before the next output.
- CLKEN_PERIOD=55. Required: fir_clk_en stays 0 until the first handshake, then pulses at +56, +112, ... cycles, and stops after clear.

Source files
------------

// File: rtl/decim_pkg.sv
// Shared sizing and arithmetic helpers for the TDM accumulate-and-dump decimator.
package decim_pkg;

    // Accumulator width: room for 2^MAX_LOG2_RATIO full-scale samples.
    function automatic int acc_w(input int data_w, input int max_log2_ratio);
        return data_w + max_log2_ratio;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int chw(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Requested log2 ratio limited to the largest supported value.
    function automatic int unsigned clamp_k(input int unsigned req, input int unsigned max_k);
        return (req > max_k) ? max_k : req;
    endfunction

    // Half-LSB offset added before the arithmetic shift (round half up).
    function automatic int unsigned rnd_off(input int unsigned k);
        return (k == 0) ? 32'd0 : (32'd1 << (k - 1));
    endfunction

endpackage

// File: rtl/decim_clken_gen.sv
// Periodic clock-enable for the downstream FIR; free-runs once the first output
// handshake has been seen, until reset or clear.
module decim_clken_gen #(
    parameter int CLKEN_PERIOD = 55
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic start_evt,
    output logic fir_clk_en
);

    localparam int CW = (CLKEN_PERIOD > 0) ? $clog2(CLKEN_PERIOD + 1) : 1;

    logic          r_start;
    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap     = (r_cnt == CW'(CLKEN_PERIOD));
    assign fir_clk_en = r_start && w_wrap;

    // Start flag latches on the first handshake; counter runs 0..CLKEN_PERIOD while started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else if (clear) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (start_evt) begin
                r_start <= 1'b1;
            end
            if (r_start) begin
                r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/decim_avg_tdm.sv
// Time-division multi-channel accumulate-and-dump decimator with a runtime
// power-of-two ratio, round-half-up averaging and ready/valid on both sides.
module decim_avg_tdm
    import decim_pkg::*;
#(
    parameter int DATA_W         = 24,
    parameter int CH             = 2,
    parameter int MAX_LOG2_RATIO = 4,
    parameter int CLKEN_PERIOD   = 55
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic [$clog2(MAX_LOG2_RATIO+1)-1:0]  log2_ratio,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [DATA_W-1:0]                    out_data,
    output logic [chw(CH)-1:0]                   out_ch,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 fir_clk_en
);

    localparam int ACC_W = acc_w(DATA_W, MAX_LOG2_RATIO);
    localparam int CHW   = chw(CH);
    localparam int KW    = $clog2(MAX_LOG2_RATIO + 1);
    localparam int BW    = (MAX_LOG2_RATIO > 0) ? MAX_LOG2_RATIO : 1;

    logic signed [ACC_W-1:0] r_acc [CH];
    logic [CHW-1:0]          r_ch;
    logic [BW-1:0]           r_blk;
    logic [KW-1:0]           r_k;
    logic [DATA_W-1:0]       r_out_data;
    logic [CHW-1:0]          r_out_ch;
    logic                    r_out_valid;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_out_hs;
    logic                    w_blk_start;
    logic [KW-1:0]           w_k_req;
    logic [KW-1:0]           w_k_eff;
    logic [BW-1:0]           w_blk_max;
    logic                    w_last_blk;
    logic                    w_last_ch;
    logic                    w_dump;
    logic signed [ACC_W-1:0] w_in_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_rnd;
    logic [DATA_W-1:0]       w_avg;

    assign w_in_ready  = !r_out_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready;
    assign w_out_hs    = r_out_valid && out_ready;
    assign w_blk_start = (r_ch == '0) && (r_blk == '0);
    assign w_k_req     = KW'(clamp_k(32'(log2_ratio), MAX_LOG2_RATIO));
    // The sample that opens a block already runs under the newly requested
    // ratio; r_k then holds that ratio for the rest of the block.
    assign w_k_eff     = w_blk_start ? w_k_req : r_k;

    // Last block index for the active ratio: 2^k - 1 as a mask of k ones.
    always_comb begin
        w_blk_max = '0;
        for (int unsigned i = 0; i < BW; i++) begin
            w_blk_max[i] = (i < 32'(w_k_eff));
        end
    end

    assign w_last_blk = (r_blk == w_blk_max);
    assign w_last_ch  = (r_ch == CHW'(CH - 1));
    assign w_dump     = w_accept && w_last_blk;

    assign w_in_ext = {{MAX_LOG2_RATIO{in_data[DATA_W-1]}}, in_data};
    assign w_sum    = r_acc[r_ch] + w_in_ext;
    assign w_rnd    = w_sum + ACC_W'(rnd_off(32'(w_k_eff)));
    assign w_avg    = DATA_W'(w_rnd >>> w_k_eff);

    // Per-channel accumulate; the dump sample empties its channel's accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CH; c++) begin
                r_acc[c] <= '0;
            end
        end else if (clear) begin
            for (int unsigned c = 0; c < CH; c++) begin
                r_acc[c] <= '0;
            end
        end else if (w_accept) begin
            r_acc[r_ch] <= w_dump ? '0 : w_sum;
        end
    end

    // Channel/block position and the ratio latched at each block start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch  <= '0;
            r_blk <= '0;
            r_k   <= '0;
        end else if (clear) begin
            r_ch  <= '0;
            r_blk <= '0;
            r_k   <= w_k_req;
        end else if (w_accept) begin
            if (w_blk_start) begin
                r_k <= w_k_req;
            end
            if (w_last_ch) begin
                r_ch  <= '0;
                r_blk <= w_last_blk ? '0 : r_blk + BW'(1);
            end else begin
                r_ch <= r_ch + CHW'(1);
            end
        end
    end

    // Single output register; a dump may reload it on the same edge it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
        end else if (w_dump) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_avg;
            r_out_ch    <= r_ch;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

    decim_clken_gen #(
        .CLKEN_PERIOD(CLKEN_PERIOD)
    ) u_clken (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .start_evt  (w_out_hs),
        .fir_clk_en (fir_clk_en)
    );

endmodule

// File: tb/tb_decim_avg_tdm.sv
// Self-checking bench for decim_avg_tdm: directed scenarios plus random traffic,
// all compared against a block-position/sum reference model.
module tb_decim_avg_tdm;

    localparam int DATA_W = 24;
    localparam int CH     = 2;
    localparam int MAXK   = 4;
    localparam int P      = 55;
    localparam int KW     = 3;
    localparam int CHW    = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic [KW-1:0]     log2_ratio = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [CHW-1:0]    out_ch;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              fir_clk_en;

    decim_avg_tdm #(
        .DATA_W         (DATA_W),
        .CH             (CH),
        .MAX_LOG2_RATIO (MAXK),
        .CLKEN_PERIOD   (P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .log2_ratio (log2_ratio),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fir_clk_en (fir_clk_en)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position inside the current block, running sums per channel.
    longint m_sum [CH];
    int     m_pos;
    int     m_k;
    bit     m_ov;
    longint m_od;
    int     m_och;
    bit     m_started;
    longint m_e0;
    longint cyc = 0;

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clampk(input int r);
        return (r > MAXK) ? MAXK : r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) m_sum[c] = 0;
        m_pos = 0; m_k = 0; m_ov = 0; m_od = 0; m_och = 0; m_started = 0; m_e0 = 0;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: update the model at the edge, compare DUT outputs at the falling edge.
    task automatic tick();
        bit hs, acc;
        int c;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (clear) begin
            for (int i = 0; i < CH; i++) m_sum[i] = 0;
            m_pos = 0; m_ov = 0; m_started = 0; m_k = clampk(int'(log2_ratio));
        end else begin
            hs  = m_ov && out_ready;
            acc = in_valid && (!m_ov || out_ready);
            if (hs && !m_started) begin
                m_started = 1; m_e0 = cyc;
            end
            if (hs) m_ov = 0;
            if (acc) begin
                if (m_pos == 0) m_k = clampk(int'(log2_ratio));
                c = m_pos % CH;
                m_sum[c] += longint'($signed(in_data));
                if (m_pos >= CH * ((1 << m_k) - 1)) begin
                    m_od  = fdiv(m_sum[c] + ((m_k > 0) ? (64'sd1 <<< (m_k - 1)) : 0), 64'sd1 <<< m_k);
                    m_och = c;
                    m_ov  = 1;
                    m_sum[c] = 0;
                end
                m_pos = (m_pos + 1) % (CH << m_k);
            end
        end
        @(negedge clk);
        chk("out_valid", out_valid, m_ov);
        chk("in_ready", in_ready, (!m_ov || out_ready));
        chk("fir_clk_en", fir_clk_en,
            (m_started && cyc > m_e0 && ((cyc - m_e0) % (P + 1)) == P));
        if (m_ov) begin
            chk("out_data", $signed(out_data), m_od);
            chk("out_ch", out_ch, m_och);
        end
    endtask

    task automatic feed(input int d);
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        tick();
    endtask

    task automatic pulse_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    int pulses;
    int ch0_seen, ch1_seen;

    initial begin
        model_reset();
        // Reset state
        tick();
        tick();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fir_clk_en", fir_clk_en, 0);
        rst_n = 1'b1;

        // k=3: ch0 1..8, ch1 -3 x8
        log2_ratio = 3'd3;
        out_ready  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            feed(i);
            if (i == 8) begin
                chk("t1_valid0", out_valid, 1);
                chk("t1_data0", $signed(out_data), 5);
                chk("t1_ch0", out_ch, 0);
            end
            feed(-3);
            if (i == 8) begin
                chk("t1_valid1", out_valid, 1);
                chk("t1_data1", $signed(out_data), -3);
                chk("t1_ch1", out_ch, 1);
            end
        end
        in_valid = 1'b0;
        tick();

        // k=0 passthrough
        pulse_clear();
        log2_ratio = 3'd0;
        feed(7);
        chk("k0_data0", $signed(out_data), 7);
        chk("k0_ch0", out_ch, 0);
        chk("k0_rdy0", in_ready, 1);
        feed(-7);
        chk("k0_data1", $signed(out_data), -7);
        chk("k0_ch1", out_ch, 1);
        chk("k0_rdy1", in_ready, 1);
        in_valid = 1'b0;
        tick();

        // Backpressure with k=1
        pulse_clear();
        log2_ratio = 3'd1;
        feed(10);
        feed(20);
        feed(30);
        chk("bp_first", $signed(out_data), 20);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(40);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_stall_rdy", in_ready, 0);
            chk("bp_hold_data", $signed(out_data), 20);
            chk("bp_hold_ch", out_ch, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_data", $signed(out_data), 30);
        chk("bp_next_ch", out_ch, 1);
        in_valid = 1'b0;
        tick();

        // Ratio change 3 -> 1 at blk 4
        pulse_clear();
        log2_ratio = 3'd3;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) log2_ratio = 3'd1;
            feed(10);
            feed(-1);
        end
        chk("rc_blk8_ch1", $signed(out_data), -1);
        feed(2);
        feed(5);
        feed(3);
        chk("rc_pair_ch0", $signed(out_data), 3);
        feed(6);
        chk("rc_pair_ch1", $signed(out_data), 6);
        in_valid = 1'b0;
        tick();

        // Clamp: request 7 runs as ratio 16
        pulse_clear();
        log2_ratio = 3'd7;
        for (int i = 0; i < 16; i++) begin
            feed(100);
            feed(-5);
        end
        chk("clamp_ch1", $signed(out_data), -5);
        chk("clamp_ch1_id", out_ch, 1);
        in_valid = 1'b0;
        tick();

        // Clear mid-block, then clear with a pending output
        pulse_clear();
        log2_ratio = 3'd3;
        for (int i = 0; i < 10; i++) feed(1000);
        pulse_clear();
        for (int i = 0; i < 7; i++) begin
            feed(50);
            feed(60);
        end
        out_ready = 1'b0;
        feed(50);
        chk("clr_pending", out_valid, 1);
        pulse_clear();
        chk("clr_drop", out_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            feed(4);
            if (i < 7) chk("clr_no_early", out_valid, 0);
            feed(-4);
        end
        chk("clr_fresh", $signed(out_data), -4);
        in_valid = 1'b0;

        // fir_clk_en pulses after the handshake, none after clear
        for (int i = 0; i < 130; i++) tick();
        pulse_clear();
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (fir_clk_en === 1'b1) pulses++;
        end
        chk("clken_after_clear", pulses, 0);

        // Random traffic with an asynchronous reset in the middle
        ch0_seen = 0;
        ch1_seen = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = DATA_W'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) log2_ratio = KW'($urandom_range(0, 7));
            if (i == 300) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("arst_valid", out_valid, 0);
                chk("arst_data", out_data, 0);
                chk("arst_rdy", in_ready, 1);
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
            if (out_valid === 1'b1 && out_ch === 1'b0) ch0_seen++;
            if (out_valid === 1'b1 && out_ch === 1'b1) ch1_seen++;
        end
        chk("rand_ch0_outputs", (ch0_seen > 0), 1);
        chk("rand_ch1_outputs", (ch1_seen > 0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
